// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounced press/release tracking.
//
// Drives one column low at a time. Each column is held for SCAN_DIV clocks, and
// the synchronized rows are sampled in the last clock of that dwell. The four
// column samples make up one frame, which is classified as NONE, KEY(code) or
// MULTI. A press FSM accepts a key after DEBOUNCE identical KEY frames and
// releases it after DEBOUNCE NONE frames.
//
// Parameters:
//   SCAN_DIV  clocks each column is driven (4..65535)
//   DEBOUNCE  consecutive matching frames to accept a press or release (1..15)
// Ports:
//   clock      system clock; all state changes on its rising edge
//   reset      asynchronous, active-high reset
//   row_n      keypad rows, active-low, asynchronous to clock
//   col_n      column strobes, active-low one-hot
//   col_idx    index of the driven column
//   key_code   hex code of the last accepted key
//   key_valid  one-clock pulse for a newly accepted press
//   key_held   high while the accepted key is considered pressed
//
// Press FSM states:
//   state        | meaning
//   ST_IDLE      | no key accepted; waiting for a single-key frame
//   ST_DEBOUNCE  | candidate seen; counting identical KEY frames
//   ST_PRESSED   | key accepted and held; waiting for an empty frame
//   ST_RELEASE   | empty frames seen; counting toward release

module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [1:0] col_idx,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [3:0]  row_meta;
    logic [3:0]  row_sample;
    logic [15:0] dwell;
    logic        capture;
    logic        frame_done;

    // Frame accumulator: hit count saturates at 2, meaning "two or more".
    logic [1:0]  acc_hits;
    logic [3:0]  acc_code;
    logic [1:0]  base_hits;
    logic [3:0]  base_code;
    logic [2:0]  col_zeros;
    logic [1:0]  col_row;
    logic [3:0]  col_code;
    logic [2:0]  hit_sum;
    logic [1:0]  frame_hits;
    logic [3:0]  frame_code;
    logic        frame_none;
    logic        frame_key;

    state_t      state, state_next;
    logic [3:0]  deb_cnt, deb_cnt_next;
    logic [3:0]  candidate, candidate_next;
    logic [3:0]  key_code_next;
    logic        key_valid_next;
    logic        key_held_next;
    logic [3:0]  cnt_inc;

    // Row synchronizer; rows idle high, so reset to all ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta   <= 4'b1111;
            row_sample <= 4'b1111;
        end else begin
            row_meta   <= row_n;
            row_sample <= row_meta;
        end
    end

    // Column dwell timer. Sampling in the last dwell cycle leaves the rows
    // several cycles to settle through the synchronizer after a column change.
    assign capture    = (dwell == DWELL_LAST);
    assign frame_done = capture && (col_idx == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dwell   <= 16'd0;
            col_idx <= 2'd0;
        end else if (capture) begin
            dwell   <= 16'd0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell   <= dwell + 16'd1;
        end
    end

    assign col_n = ~(4'b0001 << col_idx);

    // Per-column decode of the sampled rows.
    always_comb begin
        col_zeros = 3'd0;
        col_row   = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sample[r]) begin
                col_zeros = col_zeros + 3'd1;
                col_row   = 2'(r);
            end
        end
    end

    // {row, col} + 1 wraps naturally in 4 bits, so row 3 / col 3 becomes 0.
    assign col_code = {col_row, col_idx} + 4'd1;

    // Column 0 starts a fresh frame, so the previous frame's totals are ignored.
    assign base_hits = (col_idx == 2'd0) ? 2'd0 : acc_hits;
    assign base_code = (col_idx == 2'd0) ? 4'd0 : acc_code;
    assign hit_sum   = {1'b0, base_hits} + col_zeros;

    always_comb begin
        frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code = (base_hits == 2'd1) ? base_code : col_code;
    end

    assign frame_none = (frame_hits == 2'd0);
    assign frame_key  = (frame_hits == 2'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (capture) begin
            acc_hits <= frame_hits;
            acc_code <= frame_code;
        end
    end

    // Press FSM: state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            deb_cnt   <= 4'd0;
            candidate <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            deb_cnt   <= deb_cnt_next;
            candidate <= candidate_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

    assign cnt_inc = deb_cnt + 4'd1;

    // Press FSM: next state. Everything advances only on a completed frame.
    always_comb begin
        state_next     = state;
        deb_cnt_next   = deb_cnt;
        candidate_next = candidate;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_held_next  = key_held;

        if (frame_done) begin
            unique case (state)
                ST_IDLE: begin
                    if (frame_key) begin
                        candidate_next = frame_code;
                        deb_cnt_next   = 4'd1;
                        if (DEB_TARGET == 4'd1) begin
                            state_next     = ST_PRESSED;
                            key_code_next  = frame_code;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (frame_key && (frame_code == candidate)) begin
                        deb_cnt_next = cnt_inc;
                        if (cnt_inc == DEB_TARGET) begin
                            state_next     = ST_PRESSED;
                            key_code_next  = candidate;
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                        end
                    end else begin
                        state_next   = ST_IDLE;
                        deb_cnt_next = 4'd0;
                    end
                end

                ST_PRESSED: begin
                    // Any key activity keeps the press alive; no auto-repeat.
                    if (frame_none) begin
                        if (DEB_TARGET == 4'd1) begin
                            state_next    = ST_IDLE;
                            deb_cnt_next  = 4'd0;
                            key_held_next = 1'b0;
                        end else begin
                            state_next   = ST_RELEASE;
                            deb_cnt_next = 4'd1;
                        end
                    end
                end

                ST_RELEASE: begin
                    if (frame_none) begin
                        deb_cnt_next = cnt_inc;
                        if (cnt_inc == DEB_TARGET) begin
                            state_next    = ST_IDLE;
                            deb_cnt_next  = 4'd0;
                            key_held_next = 1'b0;
                        end
                    end else begin
                        state_next   = ST_PRESSED;
                        deb_cnt_next = 4'd0;
                    end
                end

                default: begin
                    state_next   = ST_IDLE;
                    deb_cnt_next = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2.
// A combinational keypad model turns a 16-bit pressed-key mask (bit 4*r+c)
// into row_n from the DUT's col_n. Expected key_valid pulses are queued with
// their code and cycle; a monitor pops and compares them as they appear.

module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DB    = 2;
    localparam int FRAME = 4 * SD;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [1:0] col_idx;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = 16'h0000;
    int          cyc;
    int          tests = 0;
    int          fails = 0;
    int          frame = 0;
    logic        held_pre;
    logic        prev_valid = 1'b0;
    logic [3:0]  ecol;

    typedef struct {
        logic [3:0] code;
        int         cycle;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clock    (clock),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .col_idx  (col_idx),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clock = ~clock;

    // Keypad: a pressed key at (r,c) pulls row r low while column c is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Clocks since reset deassertion.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d, t=%0t)", name, act, exp_v, cyc, $time);
        end
    endtask

    // Monitor: column sequence follows from elapsed clocks; pulses go to the scoreboard.
    always @(negedge clock) begin
        check("col_idx", int'(col_idx), (cyc / SD) % 4);
        ecol = 4'b0001 << ((cyc / SD) % 4);
        ecol = ~ecol;
        check("col_n", int'(col_n), int'(ecol));
        if (key_valid) begin
            check("valid_back_to_back", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                check("unexpected_key_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_code", int'(key_code), int'(e.code));
                check("pulse_cycle", cyc, e.cycle);
            end
        end
        prev_valid = key_valid;
    end

    // Expect a pulse one clock after the col 3 capture of frame f_done.
    task automatic expect_pulse(input logic [3:0] code, input int f_done);
        exp_t x;
        x.code  = code;
        x.cycle = FRAME * (f_done + 1);
        sb.push_back(x);
    endtask

    // Applies a key mask for one whole frame; ends just after the frame's last edge.
    task automatic run_frame(input logic [15:0] k);
        keys = k;
        repeat (FRAME - 1) @(posedge clock);
        #1 held_pre = key_held;
        @(posedge clock);
        #1;
        frame++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        keys  = 16'h0000;
        repeat (3) @(negedge clock);
        check("rst_col_n", int'(col_n), 4'hE);
        check("rst_col_idx", int'(col_idx), 0);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held", int'(key_held), 0);
        reset = 1'b0;
        frame = 0;
    endtask

    initial begin
        do_reset();

        // Idle scanning, nothing pressed.
        repeat (10) run_frame(16'h0000);
        check("idle_held", int'(key_held), 0);
        check("idle_code", int'(key_code), 0);

        // Row 1 / col 2 -> code 7, accepted at the end of the second frame.
        expect_pulse(4'h7, frame + 1);
        repeat (3) run_frame(16'h0001 << 6);
        check("r1c2_held", int'(key_held), 1);
        check("r1c2_code", int'(key_code), 4'h7);
        // Extra keys while pressed: no new pulse, press stays.
        run_frame((16'h0001 << 6) | 16'h0001);
        run_frame(16'h0001);
        check("pressed_other_held", int'(key_held), 1);
        check("pressed_other_code", int'(key_code), 4'h7);
        repeat (2) run_frame(16'h0000);
        check("r1c2_release_held", int'(key_held), 0);
        check("r1c2_release_code", int'(key_code), 4'h7);

        // Release bounce: one empty frame then the key returns.
        expect_pulse(4'h6, frame + 1);
        repeat (2) run_frame(16'h0001 << 5);
        run_frame(16'h0000);
        run_frame(16'h0001 << 5);
        check("bounce_back_held", int'(key_held), 1);
        check("bounce_back_code", int'(key_code), 4'h6);
        repeat (2) run_frame(16'h0000);
        check("r1c1_release_held", int'(key_held), 0);

        // Row 3 / col 3 -> code 0; key_held falls one clock after the release frame.
        expect_pulse(4'h0, frame + 1);
        repeat (2) run_frame(16'h0001 << 15);
        check("r3c3_code", int'(key_code), 4'h0);
        check("r3c3_held", int'(key_held), 1);
        run_frame(16'h0000);
        check("r3c3_release1_held", int'(key_held), 1);
        run_frame(16'h0000);
        check("r3c3_held_before_fall", int'(held_pre), 1);
        check("r3c3_held_after_fall", int'(key_held), 0);

        // Two keys across columns, then two keys in one column: MULTI, no pulse.
        repeat (4) run_frame(16'h0001 | (16'h0001 << 9));
        check("multi_cols_code", int'(key_code), 4'h0);
        check("multi_cols_held", int'(key_held), 0);
        repeat (3) run_frame(16'h0001 | (16'h0001 << 4));
        check("multi_col_held", int'(key_held), 0);

        // Different key during debounce restarts from idle.
        run_frame(16'h0001 << 2);
        run_frame(16'h0001 << 3);
        run_frame(16'h0000);
        check("diff_key_held", int'(key_held), 0);
        check("diff_key_code", int'(key_code), 4'h0);

        // Single-frame bounce.
        run_frame(16'h0001 << 1);
        run_frame(16'h0000);
        check("bounce_held", int'(key_held), 0);

        // Row 2 / col 3 interrupted by reset in its second debounce frame.
        run_frame(16'h0001 << 11);
        keys = 16'h0001 << 11;
        repeat (8) @(posedge clock);
        #1;
        do_reset();
        repeat (2) run_frame(16'h0000);
        check("post_reset_held", int'(key_held), 0);
        check("post_reset_code", int'(key_code), 4'h0);

        // Scanner still works after reset: row 2 / col 0 -> code 9.
        expect_pulse(4'h9, frame + 1);
        repeat (2) run_frame(16'h0001 << 8);
        check("r2c0_code", int'(key_code), 4'h9);
        check("r2c0_held", int'(key_held), 1);
        repeat (2) run_frame(16'h0000);
        check("r2c0_release_held", int'(key_held), 0);

        check("missing_pulses", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven; legal range 4..65535.
REQ-002 Parameter DEBOUNCE, default 4: consecutive identical scan frames needed to accept a press or release; legal range 1..15.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row_n  input  4  keypad row lines, active-low, asynchronous to clock; bit r = row r.
REQ-006 col_n  output  4  keypad column strobes, active-low one-hot; bit c low = column c driven.
REQ-007 col_idx  output  2  index of the currently driven column; always equals the position of the zero in col_n.
REQ-008 key_code  output  4  hex code of the last accepted key; held until the next accepted press.
REQ-009 key_valid  output  1  one-clock pulse marking a newly accepted press.
REQ-010 key_held  output  1  high while an accepted key is considered pressed.

Function
REQ-011 row_n SHALL pass through a two-flop synchronizer before any use; "row sample" means the synchronizer output.
REQ-012 A dwell counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap col_idx SHALL advance by 1, 3 wrapping to 0, and col_n SHALL update in the same cycle.
REQ-013 The row sample SHALL be captured only in the dwell cycle where the counter equals SCAN_DIV-1, giving at least two settle cycles after a column change.
REQ-014 Key code for row r (0..3) and column c (0..3) SHALL be (4*r + c + 1) mod 16: row0 -> 1,2,3,4; row1 -> 5..8; row2 -> 9..C; row3 -> D,E,F,0.
REQ-015 A frame is the four column captures c=0..3; the frame result SHALL be evaluated at the col 3 capture as NONE (no zero row bits), KEY(code) (exactly one zero bit across the whole frame) or MULTI (two or more zero bits in one column or across columns).
REQ-016 Press state machine states: IDLE, DEBOUNCE, PRESSED, RELEASE; a debounce counter and candidate code register SHALL support it.
REQ-017 IDLE: KEY(k) -> DEBOUNCE with candidate=k and count=1; NONE/MULTI -> stay.
REQ-018 DEBOUNCE: KEY equal to candidate increments count; NONE, MULTI or a different KEY -> IDLE.
REQ-019 Acceptance: when count reaches DEBOUNCE, including the first frame if DEBOUNCE=1, -> PRESSED, key_code=candidate, key_held=1, and key_valid=1 for exactly the next clock.
REQ-020 PRESSED: NONE -> RELEASE with count=1; KEY of any code or MULTI -> stay, with no new key_valid (no auto-repeat).
REQ-021 RELEASE: NONE increments count; at count=DEBOUNCE -> IDLE and key_held=0; KEY or MULTI -> PRESSED with key_held still 1.
REQ-022 key_valid SHALL never be high for two consecutive cycles; key_code SHALL change only on the cycle key_valid rises.
REQ-023 key_valid and the key_code update SHALL occur one clock after the col 3 capture that completes debounce.

Reset
REQ-024 While reset is high: col_n=4'b1110, col_idx=0, dwell counter=0, synchronizer=4'b1111, state=IDLE, debounce count=0, candidate=0, key_code=0, key_valid=0, key_held=0.
REQ-025 Reset asserted mid-frame, mid-debounce or while PRESSED SHALL abandon the partial frame with no key_valid pulse; scanning restarts at column 0, dwell 0, on the first edge after deassertion.

Verification (SCAN_DIV=4, DEBOUNCE=2, frame = 16 clocks)
REQ-026 Reset, row_n=4'b1111 for 10 frames -> col_n cycles 1110,1101,1011,0111 every 4 clocks; key_valid never 1; key_held=0.
REQ-027 Drive row_n[1]=0 only while col_idx=2 for 3 frames -> exactly one key_valid pulse at the end of frame 2 with key_code=4'h7; key_held=1.
REQ-028 Row3/col3 held 2 frames, then released 2 frames -> key_code=4'h0 with one pulse; key_held falls one clock after the second NONE frame's col 3 capture.
REQ-029 Row0 in col0 and row2 in col1 pressed together for 4 frames -> no key_valid; key_code keeps its prior value.
REQ-030 Single-frame bounce (row0/col1 for 1 frame, then NONE) -> no key_valid; reset asserted during the second debounce frame of row2/col3 -> no pulse, outputs at REQ-024 values.
